// File: rtl/bin2bcd_display_if.sv
// Handshake and result bundle between the display I/O register and the BCD converter.
// The master drives the binary value; the slave returns the packed BCD result and status.
interface bin2bcd_display_if #(
   parameter int BIN_WIDTH = 32
);
   logic                 in_valid;
   logic                 in_ready;
   logic [BIN_WIDTH-1:0] bin_in;
   logic [31:0]          bcd_out;
   logic                 done;
   logic                 ovf;

   modport master (
      output in_valid,
      output bin_in,
      input  in_ready,
      input  bcd_out,
      input  done,
      input  ovf
   );

   modport slave (
      input  in_valid,
      input  bin_in,
      output in_ready,
      output bcd_out,
      output done,
      output ovf
   );
endinterface

// File: rtl/bin2bcd_display.sv
// Iterative double-dabble converter feeding the 8-digit seven-segment controller.
// Only the final result reaches bcd_out; shift-register contents stay internal.
module bin2bcd_display #(
   parameter int BIN_WIDTH = 32,
   parameter int NDIG      = 8
) (
   input logic               clk,
   input logic               rst_n,
   bin2bcd_display_if.slave  bus
);
   localparam int BCD_W = 4 * NDIG;
   localparam int CW    = $clog2(BIN_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                 state_q, state_d;
   logic [BCD_W-1:0]       bcdShift_q, bcdShift_d;
   logic [BIN_WIDTH-1:0]   binShift_q, binShift_d;
   logic [CW-1:0]          count_q, count_d;
   logic                   ovfFlag_q, ovfFlag_d;
   logic [BCD_W-1:0]       bcdOut_q, bcdOut_d;
   logic                   ovf_q, ovf_d;
   logic                   done_q, done_d;

   logic [BCD_W-1:0]           corrected;
   logic [BCD_W+BIN_WIDTH-1:0] shifted;
   logic [31:0]                binExt;
   logic                       ovfIn;

   // Narrow instances can never exceed eight decimal digits, so the compare folds to 0.
   assign binExt = 32'(bus.bin_in);
   assign ovfIn  = (BIN_WIDTH >= 27) && (binExt > 32'd99_999_999);

   assign bus.in_ready = (state_q == IDLE);
   assign bus.bcd_out  = bcdOut_q;
   assign bus.done     = done_q;
   assign bus.ovf      = ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bcdShift_q <= '0;
         binShift_q <= '0;
         count_q    <= '0;
         ovfFlag_q  <= 1'b0;
         bcdOut_q   <= '0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bcdShift_q <= bcdShift_d;
         binShift_q <= binShift_d;
         count_q    <= count_d;
         ovfFlag_q  <= ovfFlag_d;
         bcdOut_q   <= bcdOut_d;
         ovf_q      <= ovf_d;
         done_q     <= done_d;
      end
   end

   // All digits get their add-3 in parallel; a carry out of the top digit only happens on overflow.
   always_comb begin
      corrected = '0;
      for (int k = 0; k < NDIG; k++) begin
         corrected[4*k +: 4] = (bcdShift_q[4*k +: 4] >= 4'd5) ? bcdShift_q[4*k +: 4] + 4'd3
                                                              : bcdShift_q[4*k +: 4];
      end
      shifted = {corrected, binShift_q} << 1;
   end

   always_comb begin
      state_d    = state_q;
      bcdShift_d = bcdShift_q;
      binShift_d = binShift_q;
      count_d    = count_q;
      ovfFlag_d  = ovfFlag_q;
      bcdOut_d   = bcdOut_q;
      ovf_d      = ovf_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               bcdShift_d = '0;
               binShift_d = bus.bin_in;
               count_d    = CW'(BIN_WIDTH);
               ovfFlag_d  = ovfIn;
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            bcdShift_d = shifted[BCD_W+BIN_WIDTH-1:BIN_WIDTH];
            binShift_d = shifted[BIN_WIDTH-1:0];
            count_d    = count_q - CW'(1);
            if (count_q == CW'(1)) state_d = DONE;
         end
         DONE: begin
            bcdOut_d = ovfFlag_q ? {NDIG{4'h9}} : bcdShift_q;
            ovf_d    = ovfFlag_q;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_bin2bcd_display.sv
// Self-checking bench for bin2bcd_display: 32-bit and 16-bit instances against a decimal
// reference model, covering latency, hold, overflow saturation, back-to-back and reset abort.
module tb_bin2bcd_display;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   int nAsserts = 0;
   int nFailures = 0;

   logic [31:0] modelBcd [2];
   logic        modelOvf [2];

   bin2bcd_display_if #(.BIN_WIDTH(32)) bus32 ();
   bin2bcd_display_if #(.BIN_WIDTH(16)) bus16 ();

   bin2bcd_display #(.BIN_WIDTH(32), .NDIG(8)) u32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
   bin2bcd_display #(.BIN_WIDTH(16), .NDIG(8)) u16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

   always #5 clk = ~clk;

   // Decimal reference: digits by repeated division, saturating above eight digits.
   function automatic logic [31:0] refBcd(input longint unsigned v);
      logic [31:0] r;
      r = '0;
      if (v > 64'd99_999_999) return 32'h9999_9999;
      for (int k = 0; k < 8; k++) begin
         r[4*k +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic readReady(input bit use16);
      return use16 ? bus16.in_ready : bus32.in_ready;
   endfunction
   function automatic logic readDone(input bit use16);
      return use16 ? bus16.done : bus32.done;
   endfunction
   function automatic logic readOvf(input bit use16);
      return use16 ? bus16.ovf : bus32.ovf;
   endfunction
   function automatic logic [31:0] readBcd(input bit use16);
      return use16 ? bus16.bcd_out : bus32.bcd_out;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFailures++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic driveIn(input bit use16, input logic valid, input logic [31:0] value);
      if (use16) begin
         bus16.in_valid = valid;
         bus16.bin_in   = value[15:0];
      end else begin
         bus32.in_valid = valid;
         bus32.bin_in   = value;
      end
   endtask

   // Called just after a clock edge with the block idle; returns one tick after the result edge.
   task automatic applyStimulus(input bit use16, input logic [31:0] value,
                                input bit holdValid, input logic [31:0] nextValue);
      int              w;
      int              idx;
      longint unsigned v;
      logic [31:0]     expBcd;
      logic            expOvf;
      bit              busyOk;
      bit              holdOk;
      w      = use16 ? 16 : 32;
      idx    = use16 ? 1 : 0;
      v      = use16 ? longint'(value[15:0]) : longint'(value);
      expBcd = refBcd(v);
      expOvf = (v > 64'd99_999_999);
      busyOk = 1'b1;
      holdOk = 1'b1;
      driveIn(use16, 1'b1, value);
      checkOutput("ready_before_accept", {31'd0, readReady(use16)}, 32'd1);
      @(posedge clk); #1;
      for (int n = 1; n <= w + 1; n++) begin
         driveIn(use16, holdValid, $urandom);
         @(posedge clk); #1;
         if (n <= w) begin
            if (readReady(use16) !== 1'b0 || readDone(use16) !== 1'b0) busyOk = 1'b0;
            if (readBcd(use16) !== modelBcd[idx] || readOvf(use16) !== modelOvf[idx]) holdOk = 1'b0;
         end
      end
      checkOutput("busy_ready_low_no_done", {31'd0, busyOk}, 32'd1);
      checkOutput("output_hold_while_busy", {31'd0, holdOk}, 32'd1);
      checkOutput("done_pulse", {31'd0, readDone(use16)}, 32'd1);
      checkOutput("bcd_out", readBcd(use16), expBcd);
      checkOutput("ovf", {31'd0, readOvf(use16)}, {31'd0, expOvf});
      checkOutput("ready_after_done", {31'd0, readReady(use16)}, 32'd1);
      modelBcd[idx] = expBcd;
      modelOvf[idx] = expOvf;
      driveIn(use16, holdValid, nextValue);
      if (!holdValid) begin
         @(posedge clk); #1;
         checkOutput("done_single_cycle", {31'd0, readDone(use16)}, 32'd0);
         checkOutput("bcd_held_idle", readBcd(use16), expBcd);
      end
   endtask

   initial begin
      bit          abortOk;
      logic [31:0] r;
      modelBcd[0] = '0; modelBcd[1] = '0;
      modelOvf[0] = 1'b0; modelOvf[1] = 1'b0;
      driveIn(1'b0, 1'b0, 32'd0);
      driveIn(1'b1, 1'b0, 32'd0);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_bcd", bus32.bcd_out, 32'h0);
      checkOutput("reset_done", {31'd0, bus32.done}, 32'd0);
      checkOutput("reset_ovf", {31'd0, bus32.ovf}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      #1;
      checkOutput("ready_after_reset", {31'd0, bus32.in_ready}, 32'd1);

      $display("[TB] directed conversions");
      applyStimulus(1'b0, 32'd12345678, 1'b0, 32'd0);
      applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
      applyStimulus(1'b0, 32'd99999999, 1'b0, 32'd0);
      applyStimulus(1'b0, 32'd100000000, 1'b0, 32'd0);
      applyStimulus(1'b0, 32'hFFFF_FFFF, 1'b0, 32'd0);
      applyStimulus(1'b0, 32'd42, 1'b0, 32'd0);

      $display("[TB] back-to-back with in_valid held");
      applyStimulus(1'b0, 32'd7, 1'b1, 32'd305419896);
      applyStimulus(1'b0, 32'd305419896, 1'b0, 32'd0);

      $display("[TB] reset during conversion");
      applyStimulus(1'b0, 32'd555, 1'b0, 32'd0);
      driveIn(1'b0, 1'b1, 32'd9876543);
      @(posedge clk); #1;
      driveIn(1'b0, 1'b0, 32'd0);
      repeat (10) @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      #1;
      checkOutput("abort_bcd_cleared", bus32.bcd_out, 32'h0);
      checkOutput("abort_no_done", {31'd0, bus32.done}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      #1;
      checkOutput("abort_ready_after_release", {31'd0, bus32.in_ready}, 32'd1);
      modelBcd[0] = '0; modelBcd[1] = '0;
      modelOvf[0] = 1'b0; modelOvf[1] = 1'b0;
      abortOk = 1'b1;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus32.done !== 1'b0 || bus32.in_ready !== 1'b1 || bus32.bcd_out !== 32'h0) abortOk = 1'b0;
      end
      checkOutput("abort_stays_idle", {31'd0, abortOk}, 32'd1);
      applyStimulus(1'b0, 32'd9876543, 1'b0, 32'd0);

      $display("[TB] random 32-bit values");
      for (int i = 0; i < 8; i++) begin
         r = (i % 2 == 0) ? $urandom_range(99_999_999, 0) : $urandom;
         applyStimulus(1'b0, r, 1'b0, 32'd0);
      end

      $display("[TB] 16-bit instance");
      applyStimulus(1'b1, 32'h0000_FFFF, 1'b0, 32'd0);
      for (int i = 0; i < 4; i++) begin
         r = $urandom;
         applyStimulus(1'b1, r, 1'b0, 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFailures);
      $finish;
   end
endmodule
